// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter and access sequencer for the shared data-memory/MMIO port.
// Every transfer runs IDLE -> [WAIT] -> ACCESS -> RESP; only ACCESS touches mem_en/mem_we.

module mem_port_arbiter_slot #(
  parameter logic ID = 1'b0
) (
  input  logic grant_en,
  input  logic win,
  input  logic resp,
  input  logic id_q,
  output logic gnt,
  output logic rvalid
);
  assign gnt    = grant_en & (win == ID);
  assign rvalid = resp & (id_q == ID);
endmodule

module mem_port_arbiter #(
  parameter int          IO_WAIT   = 2,
  parameter logic [23:0] MMIO_PAGE = 24'h0000ff
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic        busy,
  output logic [31:0] mem_a,
  output logic [31:0] mem_d,
  output logic        mem_we,
  output logic        mem_en,
  input  logic [31:0] mem_spo
);
  localparam int NUM_M = 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam bit         HAS_WAIT = (IO_WAIT != 0);
  localparam logic [3:0] CNT_INIT = HAS_WAIT ? 4'(IO_WAIT - 1) : 4'd0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mreq_t;

  mreq_t [NUM_M-1:0] mreq;
  logic  [NUM_M-1:0] req_v, gnt_v, rvalid_v;

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        id_q, id_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic grant_en, win;

  assign mreq[0] = '{we: we0, addr: addr0, wdata: wdata0};
  assign mreq[1] = '{we: we1, addr: addr1, wdata: wdata1};
  assign req_v   = {req1, req0};

  // Gated by rstn so no grant is shown while the block is held in reset.
  assign grant_en = rstn & (state_q == IDLE) & (|req_v);
  // M1 wins if it is alone, or on a tie when M0 was served last.
  assign win      = req_v[1] & (~req_v[0] | ~last_q);

  for (genvar g = 0; g < NUM_M; g++) begin : g_slot
    mem_port_arbiter_slot #(.ID(1'(g))) u_slot (
      .grant_en (grant_en),
      .win      (win),
      .resp     (state_q == RESP),
      .id_q     (id_q),
      .gnt      (gnt_v[g]),
      .rvalid   (rvalid_v[g])
    );
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_en) begin
          id_d    = win;
          last_d  = win;
          we_d    = mreq[win].we;
          addr_d  = mreq[win].addr;
          wdata_d = mreq[win].wdata;
          if (HAS_WAIT && (addr_d[31:8] == MMIO_PAGE)) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACCESS: begin
        if (!we_q) rdata_d = mem_spo;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes decode from state only, so they drop the instant rstn asserts.
  assign mem_en  = (state_q == ACCESS);
  assign mem_we  = mem_en & we_q;
  assign mem_a   = addr_q;
  assign mem_d   = wdata_q;
  assign busy    = (state_q != IDLE);
  assign rdata   = rdata_q;
  assign gnt0    = gnt_v[0];
  assign gnt1    = gnt_v[1];
  assign rvalid0 = rvalid_v[0];
  assign rvalid1 = rvalid_v[1];

endmodule
